multi_cycle_ctrl: RTL and testbench
===================================

# multi_cycle_ctrl

Main control state machine of the multi-cycle RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback. It is the producer of every datapath select and write-enable, including `alu_src1_sel` and `alu_src2_sel` for the ALU operand muxes. It handles the request/ready handshake to instruction and data memory, and latches a sticky illegal-instruction halt.

## Interface
Parameters:
- `RESET_STATE`, default `S_IF`: state entered on reset.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inst`  in  32  instruction register contents; valid from the cycle after `ir_we`.
- `br_cond`  in  1  branch comparator result for the current instruction; valid in `S_EX`.
- `imem_rdy`  in  1  instruction memory ready; sampled only while `imem_req`=1.
- `dmem_rdy`  in  1  data memory ready; sampled only while `dmem_req`=1.
- `imem_req`  out  1  instruction fetch request.
- `dmem_req`  out  1  data memory request.
- `dmem_we`  out  1  data store enable; qualifies `dmem_req`.
- `ir_we`  out  1  instruction register write.
- `alu_src1_sel`  out  2  00 = zero, 01 = pc, 10 = rf_rdata1.
- `alu_src2_sel`  out  2  00 = imm, 01 = rf_rdata2, 10 = constant 4.
- `alu_op`  out  4  ALU operation code, encoded in the package.
- `alu_out_we`  out  1  ALU result register write.
- `rf_we`  out  1  register file write.
- `wb_sel`  out  2  00 = alu_out, 01 = load data, 10 = pc+4.
- `pc_we`  out  1  PC write.
- `pc_src_sel`  out  1  0 = pc+4, 1 = alu_out.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `illegal`  out  1  sticky illegal-instruction flag.

## Operation
- **State machine:** states `S_IF`, `S_ID`, `S_EX`, `S_MEM`, `S_WB`, `S_TRAP`. All outputs decode from the state register and the registered instruction class. There are no combinational paths from `imem_rdy`/`dmem_rdy` to any output except `ir_we`.
- **S_IF:**
  - `imem_req`=1 and held high until `imem_rdy`.
  - In the `imem_rdy` cycle, `ir_we`=1 and the next state is `S_ID`.
- **S_ID:**
  - Decode `inst[6:0]`/funct3/funct7 into a class register: R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - Any other opcode sets `illegal` and goes to `S_TRAP`. Otherwise go to `S_EX`.
- **S_EX:** `alu_out_we`=1. Selects per class (src1/src2/op):
  - R: 10/01/funct.
  - I-ALU: 10/00/funct.
  - LOAD, STORE, JALR: 10/00/ADD.
  - BRANCH, JAL, AUIPC: 01/00/ADD.
  - LUI: 00/00/ADD.
  - BRANCH also captures `br_cond` into `take_r`.
  - LOAD and STORE go to `S_MEM`; all other classes go to `S_WB`.
- **S_MEM:**
  - `dmem_req`=1 and held high until `dmem_rdy`; `dmem_we`=1 for STORE.
  - In the `dmem_rdy` cycle, go to `S_WB`.
- **S_WB:** `pc_we`=1 and `retire`=1, then go to `S_IF`.
  - `rf_we`=1 for all classes except STORE and BRANCH.
  - `wb_sel`: 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - `pc_src_sel`=1 for JAL, JALR, and BRANCH with `take_r`=1; 0 otherwise.
- **S_TRAP:** all enables 0, `illegal`=1. The only exit is reset.
- **Idle values:** in any state, every output not listed for that state is 0. `alu_src1_sel`, `alu_src2_sel` and `alu_op` are 0 outside `S_EX`.

## Timing
- **Reset:** asynchronous. The state becomes `S_IF` immediately, every output goes to 0, and `illegal` and `take_r` clear. `imem_req` rises in the first cycle after `rst` deasserts.
- **Reset mid-operation:** any outstanding memory request is abandoned; no `rf_we` or `pc_we` is issued.
- **Latency with zero-wait memory (`rdy` in the first `req` cycle):**
  - R, I-ALU, branch, jumps, LUI, AUIPC: 4 cycles.
  - LOAD and STORE: 5 cycles.
- **Wait states:** each wait cycle adds one cycle. The `req` line and `dmem_we` stay stable while waiting.
- **Retire:** exactly one `retire` pulse per instruction, coincident with `pc_we`.

## Structure
- **`ctrl_pkg`:**
  - State enum.
  - Class enum.
  - `alu_src1_sel`, `alu_src2_sel`, `wb_sel` and `pc_src_sel` encodings, shared with the datapath muxes.
  - ALU op codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
  - RV32I opcode constants.
- **Sub-module `ctrl_decode`:** combinational; maps `inst` to the class, `alu_op` and a legal flag. Instantiated once; its outputs are registered in `S_ID`.

## Test plan
- **ADD (R-type) `0x002081B3`, zero-wait memory:** in `S_EX`, sels 10/01 and op 0. Exactly 4 cycles after reset release: `rf_we`=1, `wb_sel`=00, `pc_we`=1, `pc_src_sel`=0, `retire`=1.
- **LW with `dmem_rdy` delayed 3 cycles:** `dmem_req` is high for 4 cycles with `dmem_we`=0. `S_WB` has `wb_sel`=01. Total 8 cycles.
- **BEQ with `br_cond`=1, then again with `br_cond`=0:**
  - In `S_EX`, sels 01/00.
  - In `S_WB`, `pc_src_sel` is 1 for the first run and 0 for the second; `rf_we`=0 in both.
- **JAL, then LUI:**
  - JAL: `wb_sel`=10 and `pc_src_sel`=1.
  - LUI: `alu_src1_sel`=00 and `alu_src2_sel`=00.
- **Opcode `0x7F`:** `illegal` rises after `S_ID`. No further `imem_req`, `pc_we` or `rf_we` until reset. Reset then clears `illegal` and fetch resumes.
- **`rst` asserted mid-`S_MEM` of a SW:** `dmem_req` and `dmem_we` drop in the same cycle, with no `pc_we` or `retire`. After release, `imem_req`=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, instruction
// classes, datapath mux selects, ALU op codes and base opcodes.
package ctrl_pkg;

    // FSM state encodings, kept as plain constants for legacy netlists and probes
    typedef logic [2:0] state_t;
    localparam state_t S_IF   = 3'd0;
    localparam state_t S_ID   = 3'd1;
    localparam state_t S_EX   = 3'd2;
    localparam state_t S_MEM  = 3'd3;
    localparam state_t S_WB   = 3'd4;
    localparam state_t S_TRAP = 3'd5;

    typedef enum logic [3:0] {
        C_R      = 4'd0,
        C_IALU   = 4'd1,
        C_LOAD   = 4'd2,
        C_STORE  = 4'd3,
        C_BRANCH = 4'd4,
        C_JAL    = 4'd5,
        C_JALR   = 4'd6,
        C_LUI    = 4'd7,
        C_AUIPC  = 4'd8
    } class_e;

    localparam logic [1:0] SRC1_ZERO = 2'b00;
    localparam logic [1:0] SRC1_PC   = 2'b01;
    localparam logic [1:0] SRC1_RS1  = 2'b10;

    localparam logic [1:0] SRC2_IMM  = 2'b00;
    localparam logic [1:0] SRC2_RS2  = 2'b01;
    localparam logic [1:0] SRC2_FOUR = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    localparam logic PC_SRC_PLUS4 = 1'b0;
    localparam logic PC_SRC_ALU   = 1'b1;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // alt selects SUB over ADD and SRA over SRL (funct7[5])
    function automatic logic [3:0] alu_funct(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        op = ALU_ADD;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Bundle between the control FSM and the datapath/memory side.
// Handshake: a request stays high until the cycle ready is seen with it; that cycle completes the transfer.
interface multi_cycle_ctrl_if;
    logic [31:0] inst;
    logic        br_cond;
    logic        imem_rdy;
    logic        dmem_rdy;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_we;
    logic [1:0]  alu_src1_sel;
    logic [1:0]  alu_src2_sel;
    logic [3:0]  alu_op;
    logic        alu_out_we;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        pc_we;
    logic        pc_src_sel;
    logic        retire;
    logic        illegal;

    modport master (
        input  inst, br_cond, imem_rdy, dmem_rdy,
        output imem_req, dmem_req, dmem_we, ir_we, alu_src1_sel, alu_src2_sel, alu_op,
               alu_out_we, rf_we, wb_sel, pc_we, pc_src_sel, retire, illegal
    );

    modport slave (
        output inst, br_cond, imem_rdy, dmem_rdy,
        input  imem_req, dmem_req, dmem_we, ir_we, alu_src1_sel, alu_src2_sel, alu_op,
               alu_out_we, rf_we, wb_sel, pc_we, pc_src_sel, retire, illegal
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational RV32I decoder: instruction word to class, ALU op and legality.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output class_e      cls,
    output logic [3:0]  op,
    output logic        legal
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign unused_fields = ^{inst[24:15], inst[11:7]};

    always_comb begin
        cls   = C_R;
        op    = ALU_ADD;
        legal = 1'b0;
        case (opcode)
            OPC_OP: begin
                cls   = C_R;
                op    = alu_funct(funct3, funct7[5]);
                legal = (funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                cls = C_IALU;
                // only the shift-right immediate uses funct7[5]; ADDI has no subtract form
                op  = alu_funct(funct3, (funct3 == 3'b101) && funct7[5]);
                if (funct3 == 3'b001)
                    legal = (funct7 == 7'h00);
                else if (funct3 == 3'b101)
                    legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                else
                    legal = 1'b1;
            end
            OPC_LOAD: begin
                cls   = C_LOAD;
                legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            end
            OPC_STORE: begin
                cls   = C_STORE;
                legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            end
            OPC_BRANCH: begin
                cls   = C_BRANCH;
                legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OPC_JAL: begin
                cls   = C_JAL;
                legal = 1'b1;
            end
            OPC_JALR: begin
                cls   = C_JALR;
                legal = (funct3 == 3'b000);
            end
            OPC_LUI: begin
                cls   = C_LUI;
                legal = 1'b1;
            end
            OPC_AUIPC: begin
                cls   = C_AUIPC;
                legal = 1'b1;
            end
            default: begin
                cls   = C_R;
                legal = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: fetch, decode, execute, memory,
// writeback, plus a sticky trap on illegal instructions.
module multi_cycle_ctrl
    import ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = S_IF
) (
    input  logic                 clk,
    input  logic                 rst,
    multi_cycle_ctrl_if.master   bus,
    output logic [2:0]           state_dbg
);
    state_t     state_r;
    state_t     state_nx;
    class_e     cls_r;
    logic [3:0] op_r;
    logic       take_r;
    logic       illegal_r;

    class_e     dec_cls;
    logic [3:0] dec_op;
    logic       dec_legal;

    ctrl_decode u_decode (
        .inst  (bus.inst),
        .cls   (dec_cls),
        .op    (dec_op),
        .legal (dec_legal)
    );

    assign state_dbg = state_r;

    always_comb begin
        state_nx = state_r;
        case (state_r)
            S_IF:    if (bus.imem_rdy) state_nx = S_ID;
            S_ID:    state_nx = dec_legal ? S_EX : S_TRAP;
            S_EX:    state_nx = ((cls_r == C_LOAD) || (cls_r == C_STORE)) ? S_MEM : S_WB;
            S_MEM:   if (bus.dmem_rdy) state_nx = S_WB;
            S_WB:    state_nx = S_IF;
            S_TRAP:  state_nx = S_TRAP;
            default: state_nx = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= RESET_STATE;
            cls_r     <= C_R;
            op_r      <= ALU_ADD;
            take_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state_r <= state_nx;
            if (state_r == S_ID) begin
                cls_r <= dec_cls;
                op_r  <= dec_op;
                if (!dec_legal)
                    illegal_r <= 1'b1;
            end
            if ((state_r == S_EX) && (cls_r == C_BRANCH))
                take_r <= bus.br_cond;
        end
    end

    // Outputs are forced low while rst is high so a held reset issues no request
    always_comb begin
        bus.imem_req     = 1'b0;
        bus.dmem_req     = 1'b0;
        bus.dmem_we      = 1'b0;
        bus.ir_we        = 1'b0;
        bus.alu_src1_sel = SRC1_ZERO;
        bus.alu_src2_sel = SRC2_IMM;
        bus.alu_op       = ALU_ADD;
        bus.alu_out_we   = 1'b0;
        bus.rf_we        = 1'b0;
        bus.wb_sel       = WB_ALU;
        bus.pc_we        = 1'b0;
        bus.pc_src_sel   = PC_SRC_PLUS4;
        bus.retire       = 1'b0;
        bus.illegal      = illegal_r;
        if (!rst) begin
            case (state_r)
                S_IF: begin
                    bus.imem_req = 1'b1;
                    bus.ir_we    = bus.imem_rdy;
                end
                S_EX: begin
                    bus.alu_out_we = 1'b1;
                    case (cls_r)
                        C_R: begin
                            bus.alu_src1_sel = SRC1_RS1;
                            bus.alu_src2_sel = SRC2_RS2;
                            bus.alu_op       = op_r;
                        end
                        C_IALU: begin
                            bus.alu_src1_sel = SRC1_RS1;
                            bus.alu_op       = op_r;
                        end
                        C_LOAD, C_STORE, C_JALR: bus.alu_src1_sel = SRC1_RS1;
                        C_BRANCH, C_JAL, C_AUIPC: bus.alu_src1_sel = SRC1_PC;
                        default: bus.alu_src1_sel = SRC1_ZERO;
                    endcase
                end
                S_MEM: begin
                    bus.dmem_req = 1'b1;
                    bus.dmem_we  = (cls_r == C_STORE);
                end
                S_WB: begin
                    bus.pc_we  = 1'b1;
                    bus.retire = 1'b1;
                    bus.rf_we  = (cls_r != C_STORE) && (cls_r != C_BRANCH);
                    if (cls_r == C_LOAD)
                        bus.wb_sel = WB_LOAD;
                    else if ((cls_r == C_JAL) || (cls_r == C_JALR))
                        bus.wb_sel = WB_PC4;
                    if ((cls_r == C_JAL) || (cls_r == C_JALR) || ((cls_r == C_BRANCH) && take_r))
                        bus.pc_src_sel = PC_SRC_ALU;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: walks one instruction of each interesting class
// through the FSM and checks enables and selects cycle by cycle.
module tb_multi_cycle_ctrl;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] state_dbg;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl_if bus ();

    multi_cycle_ctrl #(.RESET_STATE(S_IF)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // {imem_req, dmem_req, dmem_we, ir_we, alu_out_we, rf_we, pc_we, retire}
    function automatic logic [7:0] en_vec();
        return {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we,
                bus.alu_out_we, bus.rf_we, bus.pc_we, bus.retire};
    endfunction

    // {alu_src1_sel, alu_src2_sel, alu_op, wb_sel, pc_src_sel}
    function automatic logic [10:0] sel_vec();
        return {bus.alu_src1_sel, bus.alu_src2_sel, bus.alu_op, bus.wb_sel, bus.pc_src_sel};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Zero-wait fetch from S_IF through S_ID; returns positioned in S_EX
    task automatic fetch(input string tag, input logic [31:0] word);
        bus.inst = word;
        bus.imem_rdy = 1'b1;
        #1;
        chk({tag, " if en"}, en_vec(), 8'b1001_0000);
        chk({tag, " if state"}, state_dbg, S_IF);
        cyc();
        chk({tag, " id en"}, en_vec(), 8'b0000_0000);
        chk({tag, " id state"}, state_dbg, S_ID);
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        bus.inst = 32'h0;
        bus.br_cond = 1'b0;
        bus.imem_rdy = 1'b0;
        bus.dmem_rdy = 1'b0;
        cyc();
        cyc();
        chk("reset en", en_vec(), 8'h00);
        chk("reset sel", sel_vec(), 11'h000);
        chk("reset illegal", bus.illegal, 1'b0);
        chk("reset state", state_dbg, S_IF);
        bus.imem_rdy = 1'b1;
        #1;
        chk("reset ir_we gated", en_vec(), 8'h00);

        // ADD x3,x1,x2: retire lands 4 cycles after release
        rst = 1'b0;
        fetch("add", 32'h002081B3);
        chk("add ex sel", sel_vec(), {2'b10, 2'b01, 4'd0, 2'b00, 1'b0});
        chk("add ex en", en_vec(), 8'b0000_1000);
        cyc();
        chk("add wb en", en_vec(), 8'b0000_0111);
        chk("add wb sel", sel_vec(), {2'b00, 2'b00, 4'd0, 2'b00, 1'b0});
        cyc();

        // SUB with two instruction-memory wait cycles
        bus.inst = 32'h402081B3;
        bus.imem_rdy = 1'b0;
        #1;
        chk("sub wait1 en", en_vec(), 8'b1000_0000);
        cyc();
        chk("sub wait2 en", en_vec(), 8'b1000_0000);
        chk("sub wait2 state", state_dbg, S_IF);
        cyc();
        fetch("sub", 32'h402081B3);
        chk("sub ex sel", sel_vec(), {2'b10, 2'b01, 4'd1, 2'b00, 1'b0});
        cyc();
        chk("sub wb en", en_vec(), 8'b0000_0111);
        cyc();

        // SRAI x3,x1,2
        fetch("srai", 32'h4020D193);
        chk("srai ex sel", sel_vec(), {2'b10, 2'b00, 4'd7, 2'b00, 1'b0});
        cyc();
        chk("srai wb en", en_vec(), 8'b0000_0111);
        cyc();

        // LW x3,0(x1) with dmem_rdy three cycles late: 8 cycles total
        bus.dmem_rdy = 1'b0;
        fetch("lw", 32'h0000A183);
        chk("lw ex sel", sel_vec(), {2'b10, 2'b00, 4'd0, 2'b00, 1'b0});
        chk("lw ex en", en_vec(), 8'b0000_1000);
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("lw mem wait en", en_vec(), 8'b0100_0000);
            chk("lw mem wait state", state_dbg, S_MEM);
            cyc();
        end
        bus.dmem_rdy = 1'b1;
        #1;
        chk("lw mem rdy en", en_vec(), 8'b0100_0000);
        cyc();
        bus.dmem_rdy = 1'b0;
        chk("lw wb en", en_vec(), 8'b0000_0111);
        chk("lw wb sel", sel_vec(), {2'b00, 2'b00, 4'd0, 2'b01, 1'b0});
        cyc();

        // BEQ taken: br_cond only valid in S_EX, dropped before S_WB
        bus.br_cond = 1'b1;
        fetch("beq_t", 32'h00208063);
        chk("beq_t ex sel", sel_vec(), {2'b01, 2'b00, 4'd0, 2'b00, 1'b0});
        chk("beq_t ex en", en_vec(), 8'b0000_1000);
        cyc();
        bus.br_cond = 1'b0;
        chk("beq_t wb en", en_vec(), 8'b0000_0011);
        chk("beq_t wb sel", sel_vec(), {2'b00, 2'b00, 4'd0, 2'b00, 1'b1});
        cyc();

        // BEQ not taken
        fetch("beq_n", 32'h00208063);
        chk("beq_n ex sel", sel_vec(), {2'b01, 2'b00, 4'd0, 2'b00, 1'b0});
        cyc();
        chk("beq_n wb en", en_vec(), 8'b0000_0011);
        chk("beq_n wb sel", sel_vec(), {2'b00, 2'b00, 4'd0, 2'b00, 1'b0});
        cyc();

        // JAL x1,0
        fetch("jal", 32'h000000EF);
        chk("jal ex sel", sel_vec(), {2'b01, 2'b00, 4'd0, 2'b00, 1'b0});
        cyc();
        chk("jal wb en", en_vec(), 8'b0000_0111);
        chk("jal wb sel", sel_vec(), {2'b00, 2'b00, 4'd0, 2'b10, 1'b1});
        cyc();

        // LUI x5,0x12345
        fetch("lui", 32'h123452B7);
        chk("lui ex sel", sel_vec(), {2'b00, 2'b00, 4'd0, 2'b00, 1'b0});
        chk("lui ex en", en_vec(), 8'b0000_1000);
        cyc();
        chk("lui wb en", en_vec(), 8'b0000_0111);
        chk("lui wb sel", sel_vec(), 11'h000);
        cyc();

        // Illegal opcode 0x7F: trap until reset
        bus.inst = 32'h0000007F;
        bus.imem_rdy = 1'b1;
        #1;
        chk("ill if en", en_vec(), 8'b1001_0000);
        cyc();
        chk("ill id illegal", bus.illegal, 1'b0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("ill trap en", en_vec(), 8'h00);
            chk("ill trap sel", sel_vec(), 11'h000);
            chk("ill trap flag", bus.illegal, 1'b1);
            chk("ill trap state", state_dbg, S_TRAP);
            cyc();
        end
        rst = 1'b1;
        #1;
        chk("ill reset flag", bus.illegal, 1'b0);
        chk("ill reset state", state_dbg, S_IF);
        cyc();
        bus.imem_rdy = 1'b0;
        rst = 1'b0;
        #1;
        chk("ill resume en", en_vec(), 8'b1000_0000);
        cyc();

        // SW x2,0(x1) with reset landing mid-S_MEM
        bus.dmem_rdy = 1'b0;
        fetch("sw", 32'h0020A023);
        chk("sw ex sel", sel_vec(), {2'b10, 2'b00, 4'd0, 2'b00, 1'b0});
        cyc();
        chk("sw mem en", en_vec(), 8'b0110_0000);
        cyc();
        chk("sw mem wait en", en_vec(), 8'b0110_0000);
        rst = 1'b1;
        #1;
        chk("sw reset en", en_vec(), 8'h00);
        chk("sw reset state", state_dbg, S_IF);
        cyc();
        chk("sw reset held en", en_vec(), 8'h00);
        bus.imem_rdy = 1'b0;
        rst = 1'b0;
        #1;
        chk("sw resume en", en_vec(), 8'b1000_0000);
        cyc();
        chk("sw resume wait en", en_vec(), 8'b1000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
